wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, meaning: consecutive cycles a vector result may wait behind pipeline writes before the pipeline is stalled.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 pipe_we  input  1  register-write request from the MEM/WB stage (regWrite_out).
REQ-005 pipe_rd  input  4  destination register from the MEM/WB stage.
REQ-006 pipe_data  input  16  writeback value selected by the MEM/WB result mux.
REQ-007 vec_valid  input  1  vector/crypto unit result valid.
REQ-008 vec_rd  input  4  vector result destination register.
REQ-009 vec_data  input  16  vector result value.
REQ-010 vec_ready  output  1  arbiter can accept a vector result this cycle.
REQ-011 stall_pipe  output  1  hold MEM/WB and all upstream pipeline registers.
REQ-012 rf_we  output  1  register-file write enable.
REQ-013 rf_waddr  output  4  register-file write address.
REQ-014 rf_wdata  output  16  register-file write data.
REQ-015 rf_src  output  1  source of current write: 0 = pipeline, 1 = vector.

Function
REQ-016 The block SHALL hold vector results in a 2-entry FIFO; vec_ready = FIFO not full; a push occurs when vec_valid && vec_ready.
REQ-017 The FIFO SHALL have no bypass: an entry pushed in cycle t is first eligible for grant in cycle t+1.
REQ-018 A push and a pop in the same cycle SHALL both take effect; occupancy is then unchanged.
REQ-019 The state machine SHALL have two states: NORMAL and DRAIN.
REQ-020 NORMAL, pipe_we=1: grant the pipeline; if the FIFO is non-empty, increment the starve counter (saturating at STARVE_MAX).
REQ-021 NORMAL, pipe_we=0, FIFO non-empty: grant the FIFO head, pop it, and clear the starve counter.
REQ-022 NORMAL, pipe_we=0, FIFO empty: grant nothing; rf_we=0 in the following cycle.
REQ-023 The starve counter SHALL clear whenever the FIFO is empty at the end of a cycle.
REQ-024 NORMAL -> DRAIN SHALL occur at the edge where the counter reaches STARVE_MAX; the pipeline grant in that same cycle completes normally.
REQ-025 In DRAIN, stall_pipe SHALL be 1 (registered state decode, no combinational path from inputs).
REQ-026 In DRAIN, pipe_* inputs SHALL be ignored; the held pipeline write is granted after the return to NORMAL.
REQ-027 In DRAIN, the FIFO head SHALL be granted and popped every cycle.
REQ-028 DRAIN -> NORMAL SHALL occur when a pop leaves the FIFO empty (including after a push arriving in DRAIN); the starve counter clears.
REQ-029 rf_we, rf_waddr, rf_wdata and rf_src SHALL be registered: a grant in cycle t appears on the outputs in cycle t+1 for exactly one cycle; latency is 1.
REQ-030 When nothing is granted, rf_waddr, rf_wdata and rf_src SHALL hold their previous values with rf_we=0.
REQ-031 Writes to any rd value, including 0, SHALL pass through unmodified; zero-register masking belongs to the register file.
REQ-032 Write-after-write ordering to the same rd between sources SHALL follow grant order only; no reordering or merging.

Reset
REQ-033 While reset_n=0, the block SHALL asynchronously force: state=NORMAL, FIFO empty, counter=0, stall_pipe=0, rf_we=0, rf_waddr=0, rf_wdata=0, rf_src=0.
REQ-034 vec_ready SHALL be 1 during and immediately after reset.
REQ-035 Reset asserted mid-DRAIN SHALL discard FIFO contents and deassert stall_pipe without waiting for a clock edge.

Verification
REQ-036 Pipeline only: pipe_we=1, rd=3, data=0x1234 at cycle t -> rf_we=1, waddr=3, wdata=0x1234, src=0 at t+1; stall_pipe stays 0.
REQ-037 Idle pipeline: vector push rd=5, data=0xBEEF at t -> granted at t+1 -> rf_we=1, waddr=5, src=1 at t+2.
REQ-038 Starvation: FIFO holds one entry and pipe_we=1 continuously -> four pipeline writes, then stall_pipe=1 for one cycle and the vector write appears; the held pipeline write follows.
REQ-039 Full FIFO: two pushes with no pop -> vec_ready=0; a third vec_valid is not accepted until after the first pop.
REQ-040 Reset mid-DRAIN: reset_n=0 while stall_pipe=1 with 2 entries queued -> stall_pipe=0 and rf_we=0 immediately; after release, no stale vector write ever appears.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the MEM/WB stage and the vector unit.
// Vector results queue in a 2-entry FIFO; a starve counter forces a drain.
//
// state  | meaning
// NORMAL | pipeline writes win; FIFO head granted on pipeline-idle cycles
// DRAIN  | pipeline stalled; FIFO head granted every cycle until empty
module wb_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pipe_we,
  input  logic [3:0]  pipe_rd,
  input  logic [15:0] pipe_data,
  input  logic        vec_valid,
  input  logic [3:0]  vec_rd,
  input  logic [15:0] vec_data,
  output logic        vec_ready,
  output logic        stall_pipe,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic        rf_src
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic {NORMAL = 1'b0, DRAIN = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  starve_q, starve_d;
  logic [3:0]     fifo_rd   [2];
  logic [15:0]    fifo_data [2];
  logic           wr_ptr_q, rd_ptr_q;
  logic [1:0]     count_q, count_d;
  logic           push, pop, grant_pipe, grant_vec;

  assign vec_ready  = (count_q != 2'd2);
  assign push       = vec_valid && vec_ready;
  assign stall_pipe = (state_q == DRAIN);

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    grant_pipe = 1'b0;
    grant_vec  = 1'b0;
    case (state_q)
      NORMAL: begin
        if (pipe_we) begin
          grant_pipe = 1'b1;
          if (count_q != 2'd0 && starve_q != STARVE_LIM)
            starve_d = starve_q + CW'(1);
        end else if (count_q != 2'd0) begin
          grant_vec = 1'b1;
          starve_d  = '0;
        end
      end
      DRAIN: begin
        grant_vec = (count_q != 2'd0);
      end
      default: state_d = NORMAL;
    endcase
    pop     = grant_vec;
    count_d = count_q + 2'(push) - 2'(pop);
    if (count_d == 2'd0)
      starve_d = '0;
    // The pipeline grant that saturates the counter still completes this cycle.
    if (state_q == NORMAL && grant_pipe && starve_d == STARVE_LIM)
      state_d = DRAIN;
    if (state_q == DRAIN && count_d == 2'd0)
      state_d = NORMAL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= NORMAL;
      starve_q     <= '0;
      count_q      <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      fifo_rd[0]   <= '0;
      fifo_rd[1]   <= '0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      count_q  <= count_d;
      if (push) begin
        fifo_rd[wr_ptr_q]   <= vec_rd;
        fifo_data[wr_ptr_q] <= vec_data;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop)
        rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rf_src   <= 1'b0;
    end else begin
      rf_we <= grant_pipe || grant_vec;
      if (grant_pipe) begin
        rf_waddr <= pipe_rd;
        rf_wdata <= pipe_data;
        rf_src   <= 1'b0;
      end else if (grant_vec) begin
        rf_waddr <= fifo_rd[rd_ptr_q];
        rf_wdata <= fifo_data[rd_ptr_q];
        rf_src   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, pipeline/vector grants, starvation
// drain, full FIFO back-pressure and reset in the middle of a drain.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pipe_we;
  logic [3:0]  pipe_rd;
  logic [15:0] pipe_data;
  logic        vec_valid;
  logic [3:0]  vec_rd;
  logic [15:0] vec_data;
  logic        vec_ready;
  logic        stall_pipe;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        rf_src;

  int n_assert = 0;
  int n_fail   = 0;

  wb_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pipe_we    (pipe_we),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .vec_valid  (vec_valid),
    .vec_rd     (vec_rd),
    .vec_data   (vec_data),
    .vec_ready  (vec_ready),
    .stall_pipe (stall_pipe),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rf_src     (rf_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [3:0] addr,
                        input logic [15:0] data, input logic src);
    chk({tag, ".we"},   rf_we,    we);
    chk({tag, ".addr"}, rf_waddr, addr);
    chk({tag, ".data"}, rf_wdata, data);
    chk({tag, ".src"},  rf_src,   src);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; pipe_we = 1'b0; pipe_rd = '0; pipe_data = '0;
    vec_valid = 1'b0; vec_rd = '0; vec_data = '0;
    #2;
    chk_wr("rst", 1'b0, 4'd0, 16'h0000, 1'b0);
    chk("rst.stall", stall_pipe, 1'b0);
    chk("rst.ready", vec_ready, 1'b1);
    step(); step();
    reset_n = 1'b1;
    step();
    chk("post_rst.ready", vec_ready, 1'b1);
    chk("post_rst.we", rf_we, 1'b0);

    // pipeline-only write, then idle hold
    pipe_we = 1'b1; pipe_rd = 4'd3; pipe_data = 16'h1234;
    step();
    chk_wr("pipe", 1'b1, 4'd3, 16'h1234, 1'b0);
    chk("pipe.stall", stall_pipe, 1'b0);
    pipe_rd = 4'd0; pipe_data = 16'hFFFF;
    step();
    chk_wr("pipe_r0", 1'b1, 4'd0, 16'hFFFF, 1'b0);
    pipe_we = 1'b0;
    step();
    chk_wr("idle_hold", 1'b0, 4'd0, 16'hFFFF, 1'b0);

    // vector write on idle pipeline: latency 2 from push
    vec_valid = 1'b1; vec_rd = 4'd5; vec_data = 16'hBEEF;
    step();
    vec_valid = 1'b0;
    chk("vec_push.we", rf_we, 1'b0);
    step();
    chk_wr("vec", 1'b1, 4'd5, 16'hBEEF, 1'b1);
    step();
    chk_wr("vec_hold", 1'b0, 4'd5, 16'hBEEF, 1'b1);

    // starvation: one queued entry behind continuous pipeline writes
    pipe_we = 1'b1; pipe_rd = 4'd1; pipe_data = 16'hA000;
    vec_valid = 1'b1; vec_rd = 4'd9; vec_data = 16'h9999;
    step();
    vec_valid = 1'b0;
    chk_wr("starve.p0", 1'b1, 4'd1, 16'hA000, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      pipe_rd = 4'd2; pipe_data = 16'hA000 + 16'(k);
      step();
      chk_wr($sformatf("starve.p%0d", k), 1'b1, 4'd2, 16'hA000 + 16'(k), 1'b0);
      chk($sformatf("starve.stall%0d", k), stall_pipe, (k == 4) ? 1'b1 : 1'b0);
    end
    pipe_rd = 4'd2; pipe_data = 16'hA005;
    step();
    chk("drain.stall", stall_pipe, 1'b0);
    chk_wr("drain.vec", 1'b1, 4'd9, 16'h9999, 1'b1);
    step();
    chk_wr("drain.held", 1'b1, 4'd2, 16'hA005, 1'b0);

    // full FIFO back-pressure and ordering
    pipe_rd = 4'd4; pipe_data = 16'hB001;
    vec_valid = 1'b1; vec_rd = 4'd10; vec_data = 16'h0A01;
    step();
    chk("full.ready1", vec_ready, 1'b1);
    pipe_data = 16'hB002; vec_rd = 4'd11; vec_data = 16'h0B02;
    step();
    chk_wr("full.p2", 1'b1, 4'd4, 16'hB002, 1'b0);
    chk("full.ready0", vec_ready, 1'b0);
    pipe_we = 1'b0; vec_rd = 4'd12; vec_data = 16'h0C03;
    #1;
    chk("full.ready_pre_pop", vec_ready, 1'b0);
    step();
    chk_wr("full.pop1", 1'b1, 4'd10, 16'h0A01, 1'b1);
    chk("full.ready_after", vec_ready, 1'b1);
    step();
    vec_valid = 1'b0;
    chk_wr("full.pop2", 1'b1, 4'd11, 16'h0B02, 1'b1);
    step();
    chk_wr("full.pop3", 1'b1, 4'd12, 16'h0C03, 1'b1);
    step();
    chk("full.empty_we", rf_we, 1'b0);

    // reset while draining two entries
    pipe_we = 1'b1; pipe_rd = 4'd6;
    for (int k = 1; k <= 5; k++) begin
      pipe_data = 16'h6000 + 16'(k);
      vec_valid = (k <= 2);
      vec_rd    = 4'd12 + 4'(k);
      vec_data  = 16'hD000 + 16'(k);
      step();
    end
    vec_valid = 1'b0;
    chk("rdrain.stall", stall_pipe, 1'b1);
    chk("rdrain.ready", vec_ready, 1'b0);
    chk("rdrain.we", rf_we, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rdrain.stall_async", stall_pipe, 1'b0);
    chk("rdrain.we_async", rf_we, 1'b0);
    chk("rdrain.ready_async", vec_ready, 1'b1);
    pipe_we = 1'b0;
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("rdrain.stale_we%0d", k), rf_we, 1'b0);
      chk($sformatf("rdrain.stale_stall%0d", k), stall_pipe, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
